// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, frame width, receiver states
// and the baud divider calculation used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
   localparam int BIT_W      = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } uart_rx_state_t;

   // Rounded divide so the tick rate lands as close as possible to BAUD*OVERSAMPLE.
   function automatic int calcDiv(input int clkFreq, input int baud);
      return (clkFreq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte interface of the UART: serial line in, holding register out.
// The master modport is the receiver, the slave modport is the byte consumer.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 rx;
   logic [DATA_BITS-1:0] data;
   logic                 data_valid;
   logic                 data_read;
   logic                 busy;
   logic                 framing_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      input  rx,
      input  data_read,
      output data,
      output data_valid,
      output busy,
      output framing_err,
      output parity_err,
      output overrun
   );

   modport slave (
      output rx,
      output data_read,
      input  data,
      input  data_valid,
      input  busy,
      input  framing_err,
      input  parity_err,
      input  overrun
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; o_tick is high one clock in every DIV.
// i_clear restarts the period so the next tick comes a full DIV clocks later.
module uart_baud_tick #(
   parameter int DIV = 54
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_count;

   assign o_tick = (r_count == CNT_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with a single-entry valid/read holding register.
// Define UART_RX_PARITY_EN for 8E1 framing; the default build is 8N1.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200
) (
   input logic       clk,
   input logic       reset,
   uart_rx_if.master bus
);

   localparam int DIV = calcDiv(CLK_FREQ, BAUD);

   if (DIV < 2) begin : gDivCheck
      $error("uart_rx: baud divider must be at least 2");
   end

   uart_rx_state_t       r_state;
   uart_rx_state_t       w_nextState;
   logic                 r_sync1, r_sync2, r_hist;
   logic                 w_fallEdge, w_tick, w_clear, w_lastTick, w_sample;
   logic                 w_deliver, w_framing, w_parityFail, w_parityBad;
   logic [SAMPLE_W-1:0]  r_sampleCnt;
   logic [BIT_W-1:0]     r_bitCnt;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_dataValid, r_framingErr, r_parityErr, r_overrun;

   assign w_fallEdge = r_hist & ~r_sync2;
   assign w_lastTick = (r_state == START) ? (r_sampleCnt == SAMPLE_W'(OVERSAMPLE / 2 - 1))
                                          : (r_sampleCnt == SAMPLE_W'(OVERSAMPLE - 1));
   assign w_sample   = w_tick & w_lastTick;

   uart_baud_tick #(.DIV(DIV)) uBaudTick (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState  = r_state;
      w_clear      = 1'b0;
      w_deliver    = 1'b0;
      w_framing    = 1'b0;
      w_parityFail = 1'b0;
      case (r_state)
         IDLE: if (w_fallEdge) begin
            w_nextState = START;
            w_clear     = 1'b1;
         end
         START: if (w_sample) w_nextState = r_sync2 ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA: if (w_sample && r_bitCnt == BIT_W'(DATA_BITS - 1)) w_nextState = PARITY;
         PARITY: if (w_sample) w_nextState = STOP;
`else
         DATA: if (w_sample && r_bitCnt == BIT_W'(DATA_BITS - 1)) w_nextState = STOP;
`endif
         STOP: if (w_sample) begin
            if (!r_sync2) begin
               w_framing   = 1'b1;
               w_nextState = WAIT_HIGH;
            end else if (w_parityBad) begin
               w_parityFail = 1'b1;
               w_nextState  = IDLE;
            end else begin
               w_deliver   = 1'b1;
               w_nextState = IDLE;
            end
         end
         WAIT_HIGH: if (r_sync2) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Synchronizer, sample/bit counters and the LSB-first shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_hist      <= 1'b0;
         r_sampleCnt <= '0;
         r_bitCnt    <= '0;
         r_shift     <= '0;
      end else begin
         r_sync1 <= bus.rx;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         if (w_clear) begin
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
         end else begin
            if (w_tick) r_sampleCnt <= w_lastTick ? '0 : r_sampleCnt + SAMPLE_W'(1);
            if (r_state == DATA && w_sample) begin
               r_shift  <= {r_sync2, r_shift[DATA_BITS-1:1]};
               r_bitCnt <= r_bitCnt + BIT_W'(1);
            end
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_parityBit;

   always_ff @(posedge clk) begin
      if (reset)                            r_parityBit <= 1'b0;
      else if (r_state == PARITY && w_sample) r_parityBit <= r_sync2;
   end

   assign w_parityBad = r_parityBit ^ (^r_shift);
`else
   assign w_parityBad = 1'b0;
`endif

   // Holding register: a delivery into a full, unread register is dropped as overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data       <= '0;
         r_dataValid  <= 1'b0;
         r_framingErr <= 1'b0;
         r_parityErr  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_framingErr <= w_framing;
         r_parityErr  <= w_parityFail;
         r_overrun    <= 1'b0;
         if (w_deliver) begin
            if (!r_dataValid) begin
               r_data      <= r_shift;
               r_dataValid <= 1'b1;
            end else if (bus.data_read) begin
               r_data <= r_shift;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (bus.data_read && r_dataValid) begin
            r_dataValid <= 1'b0;
         end
      end
   end

   assign bus.data        = r_data;
   assign bus.data_valid  = r_dataValid;
   assign bus.busy        = (r_state != IDLE);
   assign bus.framing_err = r_framingErr;
   assign bus.parity_err  = r_parityErr;
   assign bus.overrun     = r_overrun;

endmodule
